// File: rtl/rv_pkg.sv
// Shared RV32M definitions: funct3 opcodes and the mul/div sequencer states.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package rv_pkg;

  // RV32M funct3 encodings
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } md_op_e;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/rv_muldiv.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide.
// Latency: XLEN calc cycles plus one done cycle; div-by-zero and signed overflow finish in one.
// Backpressure: start is ignored while busy and never queued; flush aborts silently.
module rv_muldiv
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] in_1,
  input  logic [XLEN-1:0] in_2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] out
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  md_state_e         state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic              neg_q;      // final result must be negated
  logic [2*XLEN-1:0] acc;        // product, or {remainder, quotient}
  logic [XLEN-1:0]   opb;        // multiplicand or divisor magnitude
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   out_q;

  // operand decode at capture time
  logic            is_div, a_sgn, b_sgn, a_neg, b_neg, div0, ovf, fast, neg_in;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;
  logic [2*XLEN-1:0] acc_init;
  logic [XLEN-1:0]   opb_init;

  // Decode operands into magnitudes, sign fix-up flag and fast-path result
  always_comb begin
    is_div = op[2];
    a_sgn  = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_sgn  = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg  = a_sgn & in_1[XLEN-1];
    b_neg  = b_sgn & in_2[XLEN-1];
    a_mag  = a_neg ? (~in_1 + 1'b1) : in_1;
    b_mag  = b_neg ? (~in_2 + 1'b1) : in_2;
    // remainder follows the dividend; quotient and products follow the sign xor
    neg_in = (is_div && op[1]) ? a_neg : (a_neg ^ b_neg);
    div0   = is_div && (in_2 == '0);
    ovf    = ((op == OP_DIV) || (op == OP_REM)) &&
             (in_1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_2 == '1);
    fast   = div0 || ovf;
    if (div0) fast_res = op[1] ? in_1 : '1;
    else      fast_res = op[1] ? '0 : in_1;
    if (is_div) begin
      acc_init = {{XLEN{1'b0}}, a_mag};
      opb_init = b_mag;
    end else begin
      acc_init = {{XLEN{1'b0}}, b_mag};
      opb_init = a_mag;
    end
  end

  // one iteration step plus result formatting from the post-step accumulator
  logic [XLEN:0]     sum;
  logic [XLEN:0]     part;
  logic [XLEN:0]     diff;
  logic [2*XLEN-1:0] acc_nxt;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   dval;
  logic [XLEN-1:0]   result;

  // Shift-add / restoring-subtract step, then sign fix-up of the final value
  always_comb begin
    sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opb};
    part = acc[2*XLEN-1:XLEN-1];
    diff = part - {1'b0, opb};
    if (op_q[2]) begin
      // a negative difference means the divisor did not fit: keep the shifted value
      acc_nxt = diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                           : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_nxt = acc[0] ? {sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
    end
    prod = neg_q ? (~acc_nxt + 1'b1) : acc_nxt;
    dval = op_q[1] ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
    if (op_q[2])              result = neg_q ? (~dval + 1'b1) : dval;
    else if (op_q == OP_MUL)  result = prod[XLEN-1:0];
    else                      result = prod[2*XLEN-1:XLEN];
  end

  // Sequencer FSM with registered busy/done/out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      acc    <= '0;
      opb    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      out_q  <= '0;
    end else if (flush) begin
      state  <= S_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q   <= op;
            neg_q  <= neg_in;
            cnt    <= '0;
            busy_q <= 1'b1;
            if (fast) begin
              out_q  <= fast_res;
              done_q <= 1'b1;
              state  <= S_DONE;
            end else begin
              acc   <= acc_init;
              opb   <= opb_init;
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            out_q  <= result;
            done_q <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;

endmodule

// File: tb/tb_rv_muldiv.sv
// Bench for rv_muldiv at XLEN=32: vector table through a scoreboard plus abort/reset sequences.
module tb_rv_muldiv;
  import rv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] in_1;
  logic [31:0] in_2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] out;

  rv_muldiv #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .in_1  (in_1),
    .in_2  (in_2),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  vec_t        vt[$];
  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_out = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Drives one operation from an IDLE cycle; inj>0 pulses a stray start at that cycle.
  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input int inj);
    int   edges;
    int   busy_n;
    exp_t e;
    exp_t ex;
    ex.res = exp;
    ex.lat = lat;
    op    = o;
    in_1  = a;
    in_2  = b;
    start = 1'b1;
    sb.push_back(ex);
    edges  = 0;
    busy_n = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (busy) busy_n++;
      start = (inj != 0) && (edges == inj);
      // scramble inputs after capture; the DUT must not care
      op   = start ? OP_MUL : 3'($urandom);
      in_1 = $urandom;
      in_2 = $urandom;
    end while (!done && edges < 200);
    start = 1'b0;
    if (!done) begin
      chk({nm, "_timeout"}, 64'(edges), 64'(lat));
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      chk({nm, "_unexpected_done"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({nm, "_out"}, 64'(out), 64'(e.res));
      chk({nm, "_latency"}, 64'(edges), 64'(e.lat));
      chk({nm, "_busy_cycles"}, 64'(busy_n), 64'(e.lat));
      last_out = e.res;
    end
    @(posedge clk);
    #1;
    chk({nm, "_idle_busy"}, 64'(busy), 64'd0);
    chk({nm, "_idle_done"}, 64'(done), 64'd0);
    chk({nm, "_out_held"}, 64'(out), 64'(last_out));
  endtask

  task automatic watch_no_done(input string nm, input int n);
    int c;
    c = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (done) c++;
    end
    chk(nm, 64'(c), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = '0;
    in_1  = '0;
    in_2  = '0;
    flush = 1'b0;

    // MUL/MULH*/DIV*/REM* vectors; lat = edges from the sampling edge to done, inclusive
    vt.push_back('{OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
    vt.push_back('{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33});
    vt.push_back('{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
    vt.push_back('{OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33});
    vt.push_back('{OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33});
    vt.push_back('{OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33});
    vt.push_back('{OP_DIVU,   32'd100,       32'd7,         32'd14,        33});
    vt.push_back('{OP_REMU,   32'd100,       32'd7,         32'd2,         33});
    vt.push_back('{OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1});
    vt.push_back('{OP_REMU,   32'd5,         32'd0,         32'd5,         1});
    vt.push_back('{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
    vt.push_back('{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1});
    vt.push_back('{OP_DIV,    32'd7,         32'd0,         32'hFFFF_FFFF, 1});
    vt.push_back('{OP_REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1});
    vt.push_back('{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33});
    vt.push_back('{OP_MULH,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 33});
    vt.push_back('{OP_MULHU,  32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 33});
    vt.push_back('{OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33});
    vt.push_back('{OP_REM,    32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 33});
    vt.push_back('{OP_DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33});
    vt.push_back('{OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33});
    vt.push_back('{OP_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33});

    // reset state, sampled between edges
    #2;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_out",  64'(out),  64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // first op is sampled at the first edge after release; ops then run back to back
    for (int i = 0; i < vt.size(); i++) begin
      run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].exp, vt[i].lat, 0);
    end

    // stray start during CALC is dropped, not queued
    run_op("ignored_start", OP_MUL, 32'd3, 32'd5, 32'd15, 33, 10);
    watch_no_done("ignored_start_no_second_done", 40);

    // flush in the fifth cycle of a MUL
    op = OP_MUL; in_1 = 32'd2; in_2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("flush_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy_after", 64'(busy), 64'd0);
    chk("flush_done_after", 64'(done), 64'd0);
    watch_no_done("flush_no_done", 40);
    chk("flush_out_unchanged", 64'(out), 64'(last_out));

    // flush beats a simultaneous start in IDLE
    op = OP_DIVU; in_1 = 32'd9; in_2 = 32'd0; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("start_flush_busy", 64'(busy), 64'd0);
    watch_no_done("start_flush_no_done", 40);
    chk("start_flush_out_unchanged", 64'(out), 64'(last_out));

    // async reset in the middle of CALC
    op = OP_MUL; in_1 = 32'd9; in_2 = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    chk("midreset_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_done", 64'(done), 64'd0);
    chk("midreset_out",  64'(out),  64'd0);
    last_out = '0;
    watch_no_done("midreset_no_done", 3);
    rst_n = 1'b1;
    run_op("post_reset_mul", OP_MUL, 32'd6, 32'd7, 32'd42, 33, 0);
    watch_no_done("final_quiet", 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv_muldiv.md
RV_MULDIV -- requirements
Module: rv_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the operand and result width in bits (legal values 8 to 64, even).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit, requesting a new operation; sampled only in IDLE.
REQ-005 SHALL have port op, input, 3 bits, the RV32M funct3 code: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 SHALL have ports in_1 and in_2, inputs, XLEN bits each: rs1 operand and rs2 operand.
REQ-007 SHALL have port flush, input, 1 bit, a synchronous abort.
REQ-008 SHALL have port busy, output, 1 bit, high while an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit, a one-cycle pulse marking out valid.
REQ-010 SHALL have port out, output, XLEN bits, the result.

Function
REQ-011 SHALL implement FSM states IDLE, CALC and DONE.
REQ-012 SHALL, in IDLE with start=1 and flush=0, capture op, in_1 and in_2 at the edge, and SHALL thereafter ignore input changes until the next IDLE.
REQ-013 SHALL, for normal operands, stay in CALC for exactly XLEN cycles, one radix-2 shift-add or restoring-subtract step per cycle.
REQ-014 SHALL then enter DONE for one cycle, with done=1 and out valid; DONE always returns to IDLE.
REQ-015 SHALL give normal-path latency as follows: the done cycle begins XLEN+1 rising edges after the edge that sampled start.
REQ-016 SHALL use a fast path for divide-by-zero and signed overflow: IDLE goes straight to DONE, so done is high in the cycle after the sampling edge.
REQ-017 SHALL assert busy in CALC and DONE, and SHALL deassert it in IDLE.
REQ-018 SHALL ignore start whenever busy=1; it SHALL NOT be queued.
REQ-019 SHALL hold out stable from DONE until the next accepted start; out SHALL NOT glitch during CALC.
REQ-020 SHALL produce results per operation:
  MUL: low XLEN bits of the product.
  MULH: high XLEN bits, signed times signed.
  MULHSU: high XLEN bits, signed in_1 times unsigned in_2.
  MULHU: high XLEN bits, unsigned times unsigned.
REQ-021 SHALL handle signed operations by taking operand magnitudes, computing unsigned, and conditionally negating the result.
REQ-022 SHALL negate a signed quotient when the operand signs differ, and SHALL give the remainder the sign of the dividend.
REQ-023 SHALL use a 2*XLEN-bit product or partial-remainder register; intermediate arithmetic SHALL be XLEN+1 bits wide to hold the carry or borrow.
REQ-024 SHALL, on divide by zero, give DIV/DIVU = all ones and REM/REMU = in_1.
REQ-025 SHALL, for DIV with in_1 = -2^(XLEN-1) and in_2 = -1, give quotient = in_1 and REM = 0.
REQ-026 SHALL, when flush=1 at an edge in any state, go to IDLE with no done pulse and out unchanged.
REQ-027 SHALL let flush win over a simultaneous start in IDLE.
REQ-028 SHALL let a start in the cycle immediately after DONE be accepted, sustaining back-to-back operation.

Reset
REQ-029 SHALL, while rst_n=0, immediately force the state to IDLE, busy=0, done=0, out=0, and clear all internal registers, independent of clk.
REQ-030 SHALL, on reset mid-operation, discard the operation with no done pulse.
REQ-031 SHALL let the first accepted start come at the first rising edge after rst_n deasserts.

Structure
REQ-032 SHALL place the op encodings (the eight funct3 values) and the state enum in the shared package rv_pkg; the alu opcode table SHALL remain unchanged.
REQ-033 SHALL keep the FSM, counter (clog2(XLEN)+1 bits) and datapath in this one module, with no sub-module.
REQ-034 SHALL provide a core-side integration mechanism that stalls pc and reg_file write while busy=1; this is outside this block.

Verification (XLEN=32)
REQ-035 SHALL verify MUL 7 times 0xFFFFFFFD -> out 0xFFFFFFEB, with done exactly 33 edges after start and busy high 33 cycles.
REQ-036 SHALL verify MULH 0x80000000 times 0x80000000 -> 0x40000000, MULHU 0xFFFFFFFF times 0xFFFFFFFF -> 0xFFFFFFFE, and MULHSU 0xFFFFFFFF times 2 -> 0xFFFFFFFF.
REQ-037 SHALL verify DIV 0xFFFFFFF9 by 2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF, and DIVU 100 by 7 -> 14, REMU -> 2.
REQ-038 SHALL verify DIVU 5 by 0 -> 0xFFFFFFFF and REMU -> 5, and DIV 0x80000000 by 0xFFFFFFFF -> 0x80000000 and REM -> 0, all with done one edge after start.
REQ-039 SHALL verify that start pulsed at cycle 10 of a MUL is ignored (a single done), that flush at cycle 5 gives busy=0 next cycle with no done and out unchanged, and that start with flush together is not accepted.
REQ-040 SHALL verify that rst_n low mid-CALC gives busy, done and out all 0 before the next edge, and that a new MUL accepted after release completes correctly.
